// File: rtl/mips_mem_pkg.sv
// Shared types for the MIPS data-memory path: word addresses, store-buffer entries and port ops.
// Used by mips_store_buffer and mips_store_fwd_match.
package mips_mem_pkg;
  localparam int MEM_AW = 32;
  localparam int MEM_DW = 32;

  typedef logic [MEM_AW-3:0] word_addr_t;

  typedef struct packed {
    word_addr_t          addr;
    logic [MEM_DW-1:0]   data;
  } store_entry_t;

  typedef enum logic [1:0] {MEM_IDLE, MEM_LOAD, MEM_DRAIN} mem_op_e;
endpackage

// File: rtl/mips_store_fwd_match.sv
// Load-forwarding lookup over the occupied store-buffer entries.
// Entries are scanned from oldest (head) to youngest, so the last match wins.
module mips_store_fwd_match
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH)
) (
  input  store_entry_t        i_entries [DEPTH],
  input  logic [PW-1:0]       i_head,
  input  logic [PW:0]         i_count,
  input  word_addr_t          i_addr,
  output logic                o_hit,
  output logic [MEM_DW-1:0]   o_data
);

  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (((PW+1)'(i) < i_count) &&
          (i_entries[i_head + PW'(i)].addr == i_addr)) begin
        o_hit  = 1'b1;
        o_data = i_entries[i_head + PW'(i)].data;
      end
    end
  end

endmodule

// File: rtl/mips_store_buffer.sv
// Posted-write buffer between the MIPS core data port and single-ported data memory.
// Optional counters on stat_fwd/stat_stall when MIPS_STORE_BUFFER_STATS_EN is defined.
module mips_store_buffer
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = MEM_AW,
  parameter int DW    = MEM_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          core_we,
  input  logic          core_re,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic [DW-1:0] core_rdata,
  output logic          core_stall,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          buf_empty
`ifdef MIPS_STORE_BUFFER_STATS_EN
  ,
  output logic [15:0]   stat_fwd,
  output logic [15:0]   stat_stall
`endif
);

  localparam int PW = $clog2(DEPTH);

  store_entry_t  r_entries [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [PW:0]   r_count;

  mem_op_e       w_op;
  logic          w_drain;
  logic          w_enq;
  logic          w_load;
  logic          w_hit;
  logic [DW-1:0] w_hit_data;
  store_entry_t  w_head_entry;

  assign w_head_entry = r_entries[r_head];

  // A dual we+re request is a store only: it neither loads nor drains.
  always_comb begin
    w_op = MEM_IDLE;
    if (core_re) begin
      if (!core_we) w_op = MEM_LOAD;
    end else if (r_count != '0) begin
      w_op = MEM_DRAIN;
    end
  end

  assign w_load     = (w_op == MEM_LOAD);
  assign w_drain    = (w_op == MEM_DRAIN);
  assign w_enq      = core_we && ((r_count < (PW+1)'(DEPTH)) || w_drain);
  assign core_stall = core_we && (r_count == (PW+1)'(DEPTH)) && !w_drain;
  assign buf_empty  = (r_count == '0);

  assign mem_we    = w_drain;
  assign mem_addr  = w_load  ? core_addr :
                     w_drain ? {w_head_entry.addr, 2'b00} : '0;
  assign mem_wdata = w_drain ? w_head_entry.data : '0;

  mips_store_fwd_match #(.DEPTH(DEPTH)) u_fwd (
    .i_entries (r_entries),
    .i_head    (r_head),
    .i_count   (r_count),
    .i_addr    (core_addr[AW-1:2]),
    .o_hit     (w_hit),
    .o_data    (w_hit_data)
  );

  assign core_rdata = w_load ? (w_hit ? w_hit_data : mem_rdata) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_drain) r_head <= r_head + 1'b1;
      if (w_enq)   r_tail <= r_tail + 1'b1;
      case ({w_enq, w_drain})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry payload needs no reset; occupancy is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (w_enq) r_entries[r_tail] <= '{addr: core_addr[AW-1:2], data: core_wdata};
  end

`ifdef MIPS_STORE_BUFFER_STATS_EN
  logic [15:0] r_stat_fwd;
  logic [15:0] r_stat_stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stat_fwd   <= '0;
      r_stat_stall <= '0;
    end else begin
      if (w_load && w_hit && (r_stat_fwd != 16'hFFFF)) r_stat_fwd <= r_stat_fwd + 1'b1;
      if (core_stall && (r_stat_stall != 16'hFFFF))    r_stat_stall <= r_stat_stall + 1'b1;
    end
  end

  assign stat_fwd   = r_stat_fwd;
  assign stat_stall = r_stat_stall;
`endif

endmodule

// File: tb/tb_mips_store_buffer.sv
// Self-checking bench for mips_store_buffer: directed scenarios plus a random phase,
// with pending stores tracked in an expected queue that also serves forwarding lookups.
module tb_mips_store_buffer;
  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        core_we;
  logic        core_re;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic [31:0] core_rdata;
  logic        core_stall;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        buf_empty;

  // {word_addr[29:0], data[31:0]} of every accepted store not yet seen on the memory port
  logic [61:0] exp_q[$];

  int n_vec;
  int n_err;

  mips_store_buffer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .core_we    (core_we),
    .core_re    (core_re),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_rdata (core_rdata),
    .core_stall (core_stall),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .buf_empty  (buf_empty)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Drive one cycle from a negedge, check combinational outputs mid-cycle,
  // then update the expected queue at the rising edge.
  task automatic step(input logic we, input logic re, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] mrd);
    int          sz;
    logic        e_drain;
    logic        e_stall;
    logic [31:0] e_rdata;
    core_we    = we;
    core_re    = re;
    core_addr  = addr;
    core_wdata = wdata;
    mem_rdata  = mrd;
    #2;
    sz      = exp_q.size();
    e_drain = !re && (sz > 0);
    e_stall = we && (sz == DEPTH) && !e_drain;
    check("mem_we", 64'(mem_we), 64'(e_drain));
    if (e_drain) begin
      check("drain_addr", 64'(mem_addr), 64'({exp_q[0][61:32], 2'b00}));
      check("drain_data", 64'(mem_wdata), 64'(exp_q[0][31:0]));
    end else if (re && !we) begin
      check("load_addr", 64'(mem_addr), 64'(addr));
    end else begin
      check("idle_addr", 64'(mem_addr), 64'd0);
      check("idle_wdata", 64'(mem_wdata), 64'd0);
    end
    e_rdata = '0;
    if (re && !we) begin
      e_rdata = mrd;
      for (int i = 0; i < sz; i++)
        if (exp_q[i][61:32] == addr[31:2]) e_rdata = exp_q[i][31:0];
    end
    check("core_rdata", 64'(core_rdata), 64'(e_rdata));
    check("core_stall", 64'(core_stall), 64'(e_stall));
    check("buf_empty", 64'(buf_empty), 64'(sz == 0));
    @(posedge clk);
    if (e_drain) void'(exp_q.pop_front());
    if (we && !e_stall) exp_q.push_back({addr[31:2], wdata});
    @(negedge clk);
  endtask

  task automatic idle_until_empty();
    for (int i = 0; i < 2 * DEPTH + 2; i++)
      if (exp_q.size() != 0) step(1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_vec      = 0;
    n_err      = 0;
    reset      = 1'b0;
    core_we    = 1'b0;
    core_re    = 1'b0;
    core_addr  = '0;
    core_wdata = '0;
    mem_rdata  = '0;
    #1;
    check("rst_buf_empty", 64'(buf_empty), 64'd1);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_stall", 64'(core_stall), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // store then idle: write appears on the next cycle
    step(1'b1, 1'b0, 32'd84, 32'd7, 32'd0);
    step(1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    step(1'b0, 1'b0, 32'd0, 32'd0, 32'd0);

    // forwarding: youngest of two same-address stores wins
    step(1'b1, 1'b1, 32'd80, 32'd5, 32'd0);
    step(1'b1, 1'b1, 32'd80, 32'd9, 32'd0);
    step(1'b0, 1'b1, 32'd80, 32'd0, 32'd0);
    idle_until_empty();

    // load priority over a pending drain
    step(1'b1, 1'b0, 32'h200, 32'h11, 32'd0);
    repeat (3) step(1'b0, 1'b1, 32'd100, 32'd0, 32'd3);
    step(1'b0, 1'b0, 32'd0, 32'd0, 32'd0);

    // fill to DEPTH, then a store that drains and enqueues together
    idle_until_empty();
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, 1'b1, 32'h40 + 32'(4 * i), 32'hA0 + 32'(i), 32'd0);
    step(1'b1, 1'b0, 32'h60, 32'h55, 32'd0);
    // illegal dual request on a full buffer must stall
    step(1'b1, 1'b1, 32'h64, 32'h66, 32'hDEAD);
    idle_until_empty();

    // async reset between edges with three entries pending
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 32'h300 + 32'(4 * i), 32'hB0 + 32'(i), 32'd0);
    #2 reset = 1'b0;
    #1;
    check("arst_buf_empty", 64'(buf_empty), 64'd1);
    check("arst_mem_we", 64'(mem_we), 64'd0);
    check("arst_mem_addr", 64'(mem_addr), 64'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) step(1'b0, 1'b0, 32'd0, 32'd0, 32'd0);

    // random mix over a small address set so forwarding hits are frequent
    for (int n = 0; n < 300; n++) begin
      int          r;
      logic        we;
      logic        re;
      r  = int'($urandom_range(0, 9));
      we = (r < 4) || (r == 9);
      re = (r >= 4 && r < 7) || (r == 9);
      step(we, re, 32'h80 + 32'(4 * $urandom_range(0, 3)), $urandom, $urandom);
    end
    idle_until_empty();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
